// File: rtl/sprite_shifters_if.sv
`default_nettype none
// ============================================================================
// sprite_shifters_if
// Load/tick inputs and per-slot pixel outputs of the eight-slot sprite unit.
// Revision: 1.0
// ============================================================================
interface sprite_shifters_if;
  logic       ppu_tick;
  logic       shift_en;
  logic       load_en;
  logic [2:0] load_slot;
  logic [7:0] load_x;
  logic [7:0] load_attr;
  logic [7:0] load_pat_lo;
  logic [7:0] load_pat_hi;
  logic       load_sprite0;
  logic [3:0] sprite_pixel_0;
  logic [3:0] sprite_pixel_1;
  logic [3:0] sprite_pixel_2;
  logic [3:0] sprite_pixel_3;
  logic [3:0] sprite_pixel_4;
  logic [3:0] sprite_pixel_5;
  logic [3:0] sprite_pixel_6;
  logic [3:0] sprite_pixel_7;
  logic [7:0] sprite_priority_buff;
  logic       sprite0_opaque;

  modport master (
    output ppu_tick, shift_en, load_en, load_slot, load_x, load_attr,
           load_pat_lo, load_pat_hi, load_sprite0,
    input  sprite_pixel_0, sprite_pixel_1, sprite_pixel_2, sprite_pixel_3,
           sprite_pixel_4, sprite_pixel_5, sprite_pixel_6, sprite_pixel_7,
           sprite_priority_buff, sprite0_opaque
  );

  modport slave (
    input  ppu_tick, shift_en, load_en, load_slot, load_x, load_attr,
           load_pat_lo, load_pat_hi, load_sprite0,
    output sprite_pixel_0, sprite_pixel_1, sprite_pixel_2, sprite_pixel_3,
           sprite_pixel_4, sprite_pixel_5, sprite_pixel_6, sprite_pixel_7,
           sprite_priority_buff, sprite0_opaque
  );
endinterface
`default_nettype wire

// File: rtl/sprite_shifters.sv
`default_nettype none
// ============================================================================
// sprite_shifters
// Eight sprite slots: X countdown, then MSB-first pattern shift-out per dot.
// Revision: 1.0
// ============================================================================
module sprite_shifters (
  input  logic              clk,
  input  logic              rst,
  sprite_shifters_if.slave  bus_io
);

  logic [7:0] x_cnt_q [8];
  logic [7:0] x_cnt_d [8];
  logic [7:0] lo_q    [8];
  logic [7:0] lo_d    [8];
  logic [7:0] hi_q    [8];
  logic [7:0] hi_d    [8];
  logic [1:0] pal_q   [8];
  logic [1:0] pal_d   [8];
  logic [7:0] prio_q;
  logic [7:0] prio_d;
  logic       s0_q;
  logic       s0_d;
  logic [3:0] slot_pix [8];
  logic       unused_attr;

  assign unused_attr = ^{bus_io.load_attr[7], bus_io.load_attr[4:2]};

  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  always_comb begin
    prio_d = prio_q;
    s0_d   = s0_q;
    for (int n = 0; n < 8; n++) begin
      x_cnt_d[n] = x_cnt_q[n];
      lo_d[n]    = lo_q[n];
      hi_d[n]    = hi_q[n];
      pal_d[n]   = pal_q[n];
      if (bus_io.ppu_tick && bus_io.shift_en) begin
        if (x_cnt_q[n] != 8'd0) begin
          x_cnt_d[n] = x_cnt_q[n] - 8'd1;
        end else begin
          lo_d[n] = {lo_q[n][6:0], 1'b0};
          hi_d[n] = {hi_q[n][6:0], 1'b0};
        end
      end
      // A load overrides the dot update for the addressed slot only.
      if (bus_io.load_en && (bus_io.load_slot == 3'(n))) begin
        x_cnt_d[n] = bus_io.load_x;
        pal_d[n]   = bus_io.load_attr[1:0];
        prio_d[n]  = bus_io.load_attr[5];
        lo_d[n]    = bus_io.load_attr[6] ? bit_rev(bus_io.load_pat_lo) : bus_io.load_pat_lo;
        hi_d[n]    = bus_io.load_attr[6] ? bit_rev(bus_io.load_pat_hi) : bus_io.load_pat_hi;
      end
    end
    if (bus_io.load_en && (bus_io.load_slot == 3'd0)) s0_d = bus_io.load_sprite0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 8; n++) begin
        x_cnt_q[n] <= 8'hFF;
        lo_q[n]    <= 8'h00;
        hi_q[n]    <= 8'h00;
        pal_q[n]   <= 2'b00;
      end
      prio_q <= 8'h00;
      s0_q   <= 1'b0;
    end else begin
      x_cnt_q <= x_cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      pal_q   <= pal_d;
      prio_q  <= prio_d;
      s0_q    <= s0_d;
    end
  end

  for (genvar n = 0; n < 8; n++) begin : g_pix
    assign slot_pix[n] = (x_cnt_q[n] == 8'd0) ? {pal_q[n], hi_q[n][7], lo_q[n][7]} : 4'b0000;
  end

  assign bus_io.sprite_pixel_0       = slot_pix[0];
  assign bus_io.sprite_pixel_1       = slot_pix[1];
  assign bus_io.sprite_pixel_2       = slot_pix[2];
  assign bus_io.sprite_pixel_3       = slot_pix[3];
  assign bus_io.sprite_pixel_4       = slot_pix[4];
  assign bus_io.sprite_pixel_5       = slot_pix[5];
  assign bus_io.sprite_pixel_6       = slot_pix[6];
  assign bus_io.sprite_pixel_7       = slot_pix[7];
  assign bus_io.sprite_priority_buff = prio_q;
  assign bus_io.sprite0_opaque       = s0_q && (slot_pix[0][1:0] != 2'b00);

endmodule
`default_nettype wire
